// File: rtl/fan_adder_node.sv
// fan_adder_node: parametrised FAN adder node with 2-entry skid FIFO, event counters and multi-operand error flag
module fan_adder_node #(
   parameter int DW_DATA   = 8,
   parameter int DW_ROW    = 4,
   parameter int DW_CTRL   = 4,
   parameter int DW_LINE   = DW_DATA + DW_ROW + DW_CTRL,
   parameter int NUM_IN    = 8,
   parameter int OUT_LEFT  = NUM_IN / 2 - 1,
   parameter int OUT_RIGHT = NUM_IN / 2,
   parameter int SYMMETRY  = 0,
   parameter int SAT       = 0,
   parameter int CNT_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_IN*DW_LINE-1:0] in_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   output logic [NUM_IN*DW_LINE-1:0] out_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   input  logic                      cnt_clr_i,
   output logic [CNT_W-1:0]          cnt_add_o,
   output logic [CNT_W-1:0]          cnt_sat_o,
   output logic                      err_multi_o
);
   localparam int H  = NUM_IN / 2;
   localparam int NW = NUM_IN * DW_LINE;
   localparam int CB = DW_DATA + DW_ROW;

   logic [DW_LINE-1:0] l_op, r_op;
   logic               l_any, r_any, l_multi, r_multi;
   logic [DW_DATA:0]   ext;
   logic [DW_DATA-1:0] sum;
   logic               add, sat_hit, closed, res_right;
   logic [3:0]         res_ctrl;
   logic [NW-1:0]      beat;
   logic [NW-1:0]      mem_q [2];
   logic               rd_q, wr_q, in_ready_q, err_q;
   logic [1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]   cnt_add_q, cnt_add_d, cnt_sat_q, cnt_sat_d;
   logic               push, pop;

   // OR-merge the V lanes of each half into one operand and flag halves with several V lanes
   always_comb begin
      l_op    = '0;
      r_op    = '0;
      l_any   = 1'b0;
      r_any   = 1'b0;
      l_multi = 1'b0;
      r_multi = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (i < H) begin
            l_multi = l_multi | (l_any & in_i[i*DW_LINE+DW_LINE-1]);
            l_any   = l_any | in_i[i*DW_LINE+DW_LINE-1];
            l_op    = l_op | (in_i[i*DW_LINE +: DW_LINE] & {DW_LINE{in_i[i*DW_LINE+DW_LINE-1]}});
         end else begin
            r_multi = r_multi | (r_any & in_i[i*DW_LINE+DW_LINE-1]);
            r_any   = r_any | in_i[i*DW_LINE+DW_LINE-1];
            r_op    = r_op | (in_i[i*DW_LINE +: DW_LINE] & {DW_LINE{in_i[i*DW_LINE+DW_LINE-1]}});
         end
      end
   end

   assign ext       = {l_op[DW_DATA-1], l_op[DW_DATA-1:0]} + {r_op[DW_DATA-1], r_op[DW_DATA-1:0]};
   assign sat_hit   = (SAT != 0) && (ext[DW_DATA] ^ ext[DW_DATA-1]);
   assign sum       = sat_hit ? {ext[DW_DATA], {(DW_DATA-1){~ext[DW_DATA]}}} : ext[DW_DATA-1:0];
   assign add       = l_any && r_any && (l_op[DW_DATA +: DW_ROW] == r_op[DW_DATA +: DW_ROW]);
   assign closed    = (l_op[CB +: 2] == 2'b01) && (r_op[CB +: 2] == 2'b10);
   assign res_right = !closed && ((l_op[CB +: 2] == 2'b01) || ((r_op[CB +: 2] != 2'b10) && (SYMMETRY != 0)));
   assign res_ctrl  = closed ? 4'b0111 : (l_op[CB +: 2] == 2'b01) ? 4'b1001 : (r_op[CB +: 2] == 2'b10) ? 4'b1010 : 4'b1000;

   // Build the result beat: bypass on no-add, else result lane, zeroed centre partner, forwarded K lanes
   always_comb begin
      beat = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (!add)
            beat[i*DW_LINE +: DW_LINE] = in_i[i*DW_LINE +: DW_LINE];
         else if (i == (res_right ? OUT_RIGHT : OUT_LEFT))
            beat[i*DW_LINE +: DW_LINE] = {res_ctrl, l_op[DW_DATA +: DW_ROW], sum};
         else if (i != OUT_LEFT && i != OUT_RIGHT)
            beat[i*DW_LINE +: DW_LINE] = (in_i[i*DW_LINE+DW_LINE-2] && !in_i[i*DW_LINE+DW_LINE-1]) ? in_i[i*DW_LINE +: DW_LINE] : '0;
      end
   end

   assign push        = in_valid_i && in_ready_q;
   assign pop         = out_valid_o && out_ready_i;
   assign cnt_d       = cnt_q + 2'(push) - 2'(pop);
   assign cnt_add_d   = cnt_clr_i ? '0 : (push && add && !(&cnt_add_q)) ? cnt_add_q + 1'b1 : cnt_add_q;
   assign cnt_sat_d   = cnt_clr_i ? '0 : (push && add && sat_hit && !(&cnt_sat_q)) ? cnt_sat_q + 1'b1 : cnt_sat_q;
   assign out_valid_o = cnt_q != 2'd0;
   assign out_o       = out_valid_o ? mem_q[rd_q] : '0;
   assign in_ready_o  = in_ready_q;
   assign cnt_add_o   = cnt_add_q;
   assign cnt_sat_o   = cnt_sat_q;
   assign err_multi_o = err_q;

   // FIFO storage needs no reset: entries are only visible while counted
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= beat;
   end

   // FIFO pointers, registered ready, counters and sticky error
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         cnt_q      <= 2'd0;
         in_ready_q <= 1'b0;
         cnt_add_q  <= '0;
         cnt_sat_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         rd_q       <= rd_q ^ pop;
         wr_q       <= wr_q ^ push;
         cnt_q      <= cnt_d;
         in_ready_q <= cnt_d < 2'd2;
         cnt_add_q  <= cnt_add_d;
         cnt_sat_q  <= cnt_sat_d;
         err_q      <= err_q | (push && (l_multi || r_multi));
      end
   end
endmodule

// File: tb/tb_fan_adder_node.sv
// tb_fan_adder_node: directed self-checking bench for fan_adder_node (wrap, saturating and right-symmetric instances)
module tb_fan_adder_node;
   localparam int NW = 128;

   logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
   logic [NW-1:0] in_v = '0;
   logic [NW-1:0] out_w, out_s, out_y;
   logic          in_ready, in_ready_s, in_ready_y, out_valid, out_valid_s, out_valid_y;
   logic          err, err_s, err_y;
   logic [15:0]   cnt_add, cnt_sat, cnt_add_s, cnt_sat_s, cnt_add_y, cnt_sat_y;
   int            checks = 0, fails = 0, exp_add = 0;

   fan_adder_node dut (
      .clk(clk), .rst_n(rst_n), .in_i(in_v), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_o(out_w), .out_valid_o(out_valid), .out_ready_i(out_ready), .cnt_clr_i(cnt_clr),
      .cnt_add_o(cnt_add), .cnt_sat_o(cnt_sat), .err_multi_o(err));
   fan_adder_node #(.SAT(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_i(in_v), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
      .out_o(out_s), .out_valid_o(out_valid_s), .out_ready_i(out_ready), .cnt_clr_i(cnt_clr),
      .cnt_add_o(cnt_add_s), .cnt_sat_o(cnt_sat_s), .err_multi_o(err_s));
   fan_adder_node #(.SYMMETRY(1)) dut_y (
      .clk(clk), .rst_n(rst_n), .in_i(in_v), .in_valid_i(in_valid), .in_ready_o(in_ready_y),
      .out_o(out_y), .out_valid_o(out_valid_y), .out_ready_i(out_ready), .cnt_clr_i(cnt_clr),
      .cnt_add_o(cnt_add_y), .cnt_sat_o(cnt_sat_y), .err_multi_o(err_y));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [NW-1:0] b);
      in_v = b;
      in_valid = 1'b1;
      for (int t = 0; t < 10 && !in_ready; t++) step();
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL send_ready in_ready=%b required 1", in_ready); end
      step();
      in_valid = 1'b0;
   endtask

   function automatic logic [NW-1:0] bypass_beat(input int base, input int k);
      return {8{16'(base + k)}};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b required 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b required 0", in_ready); end
      checks++; if (out_w !== '0) begin fails++; $display("FAIL reset_out got=%h required 0", out_w); end
      checks++; if (cnt_add !== 16'd0 || cnt_sat_s !== 16'd0) begin fails++; $display("FAIL reset_counters add=%0d sat=%0d required 0", cnt_add, cnt_sat_s); end
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b required 0", err); end
      rst_n = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b required 1", in_ready); end
   endtask

   task automatic test_closed_add();
      logic [NW-1:0] b = '0, e = '0;
      b[1*16 +: 16] = 16'h9305;
      b[6*16 +: 16] = 16'hA307;
      e[3*16 +: 16] = 16'h730C;
      send(b);
      exp_add++;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL closed_valid got=%b required 1", out_valid); end
      checks++; if (out_w !== e) begin fails++; $display("FAIL closed_out got=%h required %h", out_w, e); end
      checks++; if (out_y !== e) begin fails++; $display("FAIL closed_out_sym got=%h required %h", out_y, e); end
      checks++; if (cnt_add !== 16'(exp_add)) begin fails++; $display("FAIL closed_cnt_add got=%0d required %0d", cnt_add, exp_add); end
   endtask

   task automatic test_row_mismatch();
      logic [NW-1:0] b = '0;
      b[0*16 +: 16] = 16'h9205;
      b[4*16 +: 16] = 16'hA307;
      send(b);
      checks++; if (out_w !== b) begin fails++; $display("FAIL mismatch_out got=%h required %h", out_w, b); end
      checks++; if (cnt_add !== 16'(exp_add)) begin fails++; $display("FAIL mismatch_cnt_add got=%0d required %0d", cnt_add, exp_add); end
   endtask

   task automatic test_ctrl_table();
      logic [NW-1:0] b = '0, e = '0;
      b[1*16 +: 16] = 16'h9305;
      b[6*16 +: 16] = 16'h8307;
      e[4*16 +: 16] = 16'h930C;
      send(b);
      exp_add++;
      checks++; if (out_w !== e) begin fails++; $display("FAIL left_closed_out got=%h required %h", out_w, e); end
      b = '0;
      e = '0;
      b[1*16 +: 16] = 16'h8305;
      b[6*16 +: 16] = 16'hA307;
      e[3*16 +: 16] = 16'hA30C;
      send(b);
      exp_add++;
      checks++; if (out_y !== e) begin fails++; $display("FAIL right_closed_out got=%h required %h", out_y, e); end
      checks++; if (cnt_add !== 16'(exp_add)) begin fails++; $display("FAIL ctrl_cnt_add got=%0d required %0d", cnt_add, exp_add); end
   endtask

   task automatic test_overflow();
      logic [NW-1:0] b = '0, e = '0, es = '0, ey = '0;
      b[2*16 +: 16]  = 16'h8564;
      b[5*16 +: 16]  = 16'h8564;
      e[3*16 +: 16]  = 16'h85C8;
      es[3*16 +: 16] = 16'h857F;
      ey[4*16 +: 16] = 16'h85C8;
      send(b);
      exp_add++;
      checks++; if (out_w !== e) begin fails++; $display("FAIL ovf_wrap_out got=%h required %h", out_w, e); end
      checks++; if (out_s !== es) begin fails++; $display("FAIL ovf_sat_out got=%h required %h", out_s, es); end
      checks++; if (out_y !== ey) begin fails++; $display("FAIL ovf_sym_out got=%h required %h", out_y, ey); end
      checks++; if (cnt_sat !== 16'd0 || cnt_sat_s !== 16'd1) begin fails++; $display("FAIL ovf_cnt_sat wrap=%0d sat=%0d required 0 and 1", cnt_sat, cnt_sat_s); end
      b = '0; e = '0; es = '0; ey = '0;
      b[2*16 +: 16]  = 16'h859C;
      b[5*16 +: 16]  = 16'h859C;
      b[7*16 +: 16]  = 16'h4155;
      e[3*16 +: 16]  = 16'h8538;
      e[7*16 +: 16]  = 16'h4155;
      es[3*16 +: 16] = 16'h8580;
      es[7*16 +: 16] = 16'h4155;
      ey[4*16 +: 16] = 16'h8538;
      ey[7*16 +: 16] = 16'h4155;
      send(b);
      exp_add++;
      checks++; if (out_w !== e) begin fails++; $display("FAIL neg_wrap_out got=%h required %h", out_w, e); end
      checks++; if (out_s !== es) begin fails++; $display("FAIL neg_sat_out got=%h required %h", out_s, es); end
      checks++; if (out_y !== ey) begin fails++; $display("FAIL neg_sym_out got=%h required %h", out_y, ey); end
      checks++; if (cnt_sat_s !== 16'd2 || cnt_add !== 16'(exp_add)) begin fails++; $display("FAIL neg_counters sat=%0d add=%0d required 2 and %0d", cnt_sat_s, cnt_add, exp_add); end
   endtask

   task automatic test_counters();
      logic [NW-1:0] b = '0;
      b[1*16 +: 16] = 16'h9305;
      b[6*16 +: 16] = 16'hA307;
      cnt_clr = 1'b1;
      send(b);
      cnt_clr = 1'b0;
      exp_add = 0;
      checks++; if (cnt_add !== 16'd0 || cnt_sat_s !== 16'd0) begin fails++; $display("FAIL clr_wins add=%0d sat=%0d required 0", cnt_add, cnt_sat_s); end
      send(b);
      exp_add++;
      checks++; if (cnt_add !== 16'(exp_add)) begin fails++; $display("FAIL clr_recount got=%0d required %0d", cnt_add, exp_add); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_v = bypass_beat(16'h1200, k);
         in_valid = 1'b1;
         checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready beat=%0d got=%b required 1", k, in_ready); end
         step();
         checks++; if (out_valid !== 1'b1 || out_w !== bypass_beat(16'h1200, k)) begin fails++; $display("FAIL b2b_out beat=%0d valid=%b got=%h required %h", k, out_valid, out_w, bypass_beat(16'h1200, k)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got=%b required 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int  idx = 0, rx = 0;
      logic acc;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_v = bypass_beat(16'h3400, idx);
         in_valid = 1'b1;
         acc = in_ready;
         step();
         if (acc) idx++;
      end
      checks++; if (idx != 2) begin fails++; $display("FAIL bp_accepted got=%0d required 2", idx); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b required 0", in_ready); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && rx < 4; c++) begin
         if (out_valid) begin
            checks++;
            if (out_w !== bypass_beat(16'h3400, rx)) begin fails++; $display("FAIL bp_order beat=%0d got=%h required %h", rx, out_w, bypass_beat(16'h3400, rx)); end
            rx++;
         end
         in_valid = idx < 4;
         in_v = bypass_beat(16'h3400, idx);
         acc = in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      checks++; if (rx != 4) begin fails++; $display("FAIL bp_count got=%0d required 4", rx); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_dup out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_multi_v();
      logic [NW-1:0] b = '0, e = '0;
      checks++; if (err !== 1'b0) begin fails++; $display("FAIL multi_pre got=%b required 0", err); end
      b[0*16 +: 16] = 16'h8201;
      b[1*16 +: 16] = 16'h8202;
      b[4*16 +: 16] = 16'h8203;
      e[3*16 +: 16] = 16'h8206;
      send(b);
      exp_add++;
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL multi_set got=%b required 1", err); end
      checks++; if (out_w !== e) begin fails++; $display("FAIL multi_out got=%h required %h", out_w, e); end
      b = '0;
      b[1*16 +: 16] = 16'h9305;
      b[6*16 +: 16] = 16'hA307;
      send(b);
      send(b);
      exp_add += 2;
      checks++; if (err !== 1'b1) begin fails++; $display("FAIL multi_sticky got=%b required 1", err); end
   endtask

   task automatic test_reset_mid();
      logic [NW-1:0] b = '0;
      b[1*16 +: 16] = 16'h9305;
      b[6*16 +: 16] = 16'hA307;
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      for (int k = 0; k < 5; k++) send(b);
      step();
      checks++; if (cnt_add !== 16'd5) begin fails++; $display("FAIL mid_cnt_add got=%0d required 5", cnt_add); end
      out_ready = 1'b0;
      send(bypass_beat(16'h5600, 0));
      send(bypass_beat(16'h5600, 1));
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL mid_full valid=%b ready=%b required 1 and 0", out_valid, in_ready); end
      rst_n = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0 || out_w !== '0) begin fails++; $display("FAIL mid_flush valid=%b out=%h required 0", out_valid, out_w); end
      checks++; if (cnt_add !== 16'd0 || err !== 1'b0) begin fails++; $display("FAIL mid_state add=%0d err=%b required 0", cnt_add, err); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL mid_ready_low got=%b required 0", in_ready); end
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_release ready=%b valid=%b required 1 and 0", in_ready, out_valid); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_closed_add();
      test_row_mismatch();
      test_ctrl_table();
      test_overflow();
      test_counters();
      test_back_to_back();
      test_backpressure();
      test_multi_v();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
